// File: rtl/rf_scoreboard_if.sv
// Bus bundle for rf_scoreboard: read ports, write port, issue port and
// the registered stray-write flag. The master drives addresses and data;
// the slave (the register file) returns read data, busy bits and STRAY.
interface rf_scoreboard_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int NRD   = 2
);
   localparam int AW = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);

   logic [NRD*AW-1:0]    RADDR;
   logic [NRD*WIDTH-1:0] RDATA;
   logic [NRD-1:0]       RBUSY;
   logic                 WEN;
   logic [AW-1:0]        WADDR;
   logic [WIDTH-1:0]     WDATA;
   logic                 ISSUE;
   logic [AW-1:0]        IADDR;
   logic                 STRAY;

   modport master (
      output RADDR, WEN, WADDR, WDATA, ISSUE, IADDR,
      input  RDATA, RBUSY, STRAY
   );

   modport slave (
      input  RADDR, WEN, WADDR, WDATA, ISSUE, IADDR,
      output RDATA, RBUSY, STRAY
   );
endinterface

// File: rtl/rf_scoreboard.sv
// Register file with a per-register busy scoreboard.
// Reads are combinational with write-first bypass. ISSUE marks a register
// as waiting for a producer; a write retires it. STRAY pulses for one cycle
// after a write lands on a register nobody was waiting for.
module rf_scoreboard #(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 32,
   parameter int               NRD      = 2,
   parameter int               ZERO_REG = 1,
   parameter int               SP_IDX   = 29,
   parameter logic [WIDTH-1:0] SP_INIT  = WIDTH'(32'h0000_3FFC)
) (
   input  logic           CLK,
   input  logic           RST_N,
   rf_scoreboard_if.slave bus
);
   localparam int AW = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);
   // One extra bit so DEPTH itself is representable for the range compare.
   localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

   // An address names a real, writable register: in range and not the
   // hard-wired zero register.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return ({1'b0, a} < DEPTH_X) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [DEPTH-1:0]     busy;
   logic [DEPTH-1:0]     busy_nxt;
   logic                 stray_q;
   logic                 wq;
   logic                 iq;
   logic [NRD*WIDTH-1:0] rdata_c;
   logic [NRD-1:0]       rbusy_c;

   // Qualified write/issue; gating with RST_N keeps reset-cycle traffic
   // from bypassing onto the read ports while the array is held cleared.
   assign wq = RST_N && bus.WEN   && addr_ok(bus.WADDR);
   assign iq = RST_N && bus.ISSUE && addr_ok(bus.IADDR);

   // Register array: reset image is all zeros except the stack pointer.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= (i == SP_IDX) ? SP_INIT : '0;
         end
      end else if (wq) begin
         mem[bus.WADDR] <= bus.WDATA;
      end
   end

   // Busy next state: a write clears, an issue sets, and the set wins
   // because a fresh producer supersedes the one just retired.
   always_comb begin
      busy_nxt = busy;
      if (wq) busy_nxt[bus.WADDR] = 1'b0;
      if (iq) busy_nxt[bus.IADDR] = 1'b1;
   end

   // Busy bits and the stray-write flag.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         busy    <= '0;
         stray_q <= 1'b0;
      end else begin
         busy    <= busy_nxt;
         stray_q <= wq && !busy[bus.WADDR];
      end
   end

   // Read ports: zero for invalid addresses, write-first bypass, and a busy
   // view that already reflects a retiring write in the same cycle.
   always_comb begin
      logic [AW-1:0] ra;
      logic          hit;
      logic          reissue;
      rdata_c = '0;
      rbusy_c = '0;
      ra      = '0;
      hit     = 1'b0;
      reissue = 1'b0;
      for (int k = 0; k < NRD; k++) begin
         ra      = bus.RADDR[k*AW +: AW];
         hit     = wq && (bus.WADDR == ra);
         reissue = iq && (bus.IADDR == ra);
         if (addr_ok(ra)) begin
            rdata_c[k*WIDTH +: WIDTH] = hit ? bus.WDATA : mem[ra];
            rbusy_c[k]                = busy[ra] && !(hit && !reissue);
         end
      end
   end

   assign bus.RDATA = rdata_c;
   assign bus.RBUSY = rbusy_c;
   assign bus.STRAY = stray_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: a default instance (DEPTH=32, NRD=2) and a
// reduced one (DEPTH=24, NRD=3) share clock and reset. Expected values are
// queued as stimulus is applied and popped as outputs are sampled.
module tb_rf_scoreboard;
   logic CLK;
   logic RST_N;

   int checks;
   int failures;

   string       tag_q [$];
   logic [63:0] exp_q [$];

   rf_scoreboard_if #(.WIDTH(32), .DEPTH(32), .NRD(2)) ia ();
   rf_scoreboard_if #(.WIDTH(32), .DEPTH(24), .NRD(3)) ib ();

   rf_scoreboard #(.WIDTH(32), .DEPTH(32), .NRD(2)) u_a (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (ia)
   );

   rf_scoreboard #(.WIDTH(32), .DEPTH(24), .NRD(3)) u_b (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (ib)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input logic [63:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic obs(input logic [63:0] got);
      string       t;
      logic [63:0] e;
      if (exp_q.size() == 0) begin
         chk("sb_underflow", 64'd1, 64'd0);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         chk(t, got, e);
      end
   endtask

   task automatic nb();
      @(negedge CLK);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks   = 0;
      failures = 0;
      RST_N    = 1'b0;
      ia.WEN = 0; ia.WADDR = '0; ia.WDATA = '0; ia.ISSUE = 0; ia.IADDR = '0; ia.RADDR = '0;
      ib.WEN = 0; ib.WADDR = '0; ib.WDATA = '0; ib.ISSUE = 0; ib.IADDR = '0; ib.RADDR = '0;

      // Traffic during reset must be discarded.
      ia.WEN = 1; ia.WADDR = 5'd5; ia.WDATA = 32'h77; ia.ISSUE = 1; ia.IADDR = 5'd5;
      ia.RADDR = {5'd5, 5'd29};
      ib.RADDR = {5'd29, 5'd23, 5'd30};
      push("rst_rd0",   64'h3FFC);
      push("rst_rd1",   64'h0);
      push("rst_busy",  64'h0);
      push("rst_stray", 64'h0);
      repeat (2) @(posedge CLK);
      nb(); #1;
      obs(ia.RDATA[31:0]); obs(ia.RDATA[63:32]); obs(ia.RBUSY); obs(ia.STRAY);

      // Release: defaults visible, reset-time write/issue left no trace.
      ia.WEN = 0; ia.ISSUE = 0; RST_N = 1'b1;
      push("def_rd0",   64'h3FFC);
      push("def_rd1",   64'h0);
      push("def_busy",  64'h0);
      push("b_sp_oor",  64'h0);
      nb(); #1;
      obs(ia.RDATA[31:0]); obs(ia.RDATA[63:32]); obs(ia.RBUSY); obs(ib.RDATA[95:64]);

      // Zero register write; B writes/issues an out-of-range address.
      nb();
      ia.WEN = 1; ia.WADDR = 5'd0; ia.WDATA = 32'hDEAD_BEEF; ia.RADDR = {5'd0, 5'd0};
      ib.WEN = 1; ib.WADDR = 5'd30; ib.WDATA = 32'hFFFF; ib.ISSUE = 1; ib.IADDR = 5'd30;
      ib.RADDR = {5'd5, 5'd23, 5'd30};
      push("zero_byp",   64'h0);
      push("b_oor_byp",  64'h0);
      push("b_oor_busy", 64'h0);
      #1;
      obs(ia.RDATA[31:0]); obs(ib.RDATA[31:0]); obs(ib.RBUSY[0]);

      nb();
      ia.WEN = 0;
      ib.WEN = 1; ib.WADDR = 5'd23; ib.WDATA = 32'hCAFE; ib.ISSUE = 0;
      push("zero_rd0",    64'h0);
      push("zero_stray",  64'h0);
      push("zero_busy",   64'h0);
      push("b_oor_rd",    64'h0);
      push("b_oor_stray", 64'h0);
      push("b_top_byp",   64'hCAFE);
      #1;
      obs(ia.RDATA[31:0]); obs(ia.STRAY); obs(ia.RBUSY);
      obs(ib.RDATA[31:0]); obs(ib.STRAY); obs(ib.RDATA[63:32]);

      // Bypass on register 7.
      nb();
      ia.WEN = 1; ia.WADDR = 5'd7; ia.WDATA = 32'h1234_5678; ia.RADDR = {5'd0, 5'd7};
      ib.WEN = 0; ib.ISSUE = 1; ib.IADDR = 5'd5;
      push("byp_rd0",     64'h1234_5678);
      push("b_top_rd",    64'hCAFE);
      push("b_top_stray", 64'h1);
      #1;
      obs(ia.RDATA[31:0]); obs(ib.RDATA[63:32]); obs(ib.STRAY);

      nb();
      ia.WEN = 0;
      ib.ISSUE = 0;
      push("byp_keep",  64'h1234_5678);
      push("byp_stray", 64'h1);
      push("b_busy5",   64'h1);
      #1;
      obs(ia.RDATA[31:0]); obs(ia.STRAY); obs(ib.RBUSY[2]);

      nb();
      push("stray_pulse", 64'h0);
      #1;
      obs(ia.STRAY);

      // Scoreboard sequence on register 3.
      nb();
      ia.ISSUE = 1; ia.IADDR = 5'd3; ia.RADDR = {5'd3, 5'd7};
      push("iss_pre", 64'h0);
      #1;
      obs(ia.RBUSY[1]);

      nb();
      ia.ISSUE = 0;
      push("iss_busy",  64'h1);
      push("iss_stray", 64'h0);
      #1;
      obs(ia.RBUSY[1]); obs(ia.STRAY);

      nb();
      ia.WEN = 1; ia.WADDR = 5'd3; ia.WDATA = 32'hA5;
      push("wr_busy_now", 64'h0);
      push("wr_byp",      64'hA5);
      #1;
      obs(ia.RBUSY[1]); obs(ia.RDATA[63:32]);

      nb();
      ia.WEN = 0;
      push("wr_stray",  64'h0);
      push("wr_busy",   64'h0);
      push("wr_rd1",    64'hA5);
      #1;
      obs(ia.STRAY); obs(ia.RBUSY[1]); obs(ia.RDATA[63:32]);

      nb();
      ia.WEN = 1; ia.WADDR = 5'd3; ia.WDATA = 32'h5A;
      nb();
      ia.WEN = 0;
      push("st2_stray", 64'h1);
      #1;
      obs(ia.STRAY);

      nb();
      push("st2_clear", 64'h0);
      #1;
      obs(ia.STRAY);

      // Simultaneous set and clear on a busy register 9.
      nb();
      ia.ISSUE = 1; ia.IADDR = 5'd9; ia.RADDR = {5'd9, 5'd9};
      nb();
      ia.WEN = 1; ia.WADDR = 5'd9; ia.WDATA = 32'h99;
      push("sc_busy_now", 64'h1);
      push("sc_byp",      64'h99);
      push("same_port",   64'h99);
      #1;
      obs(ia.RBUSY[0]); obs(ia.RDATA[31:0]); obs(ia.RDATA[63:32]);

      nb();
      ia.WEN = 0; ia.ISSUE = 0;
      push("sc_busy",  64'h3);
      push("sc_rd",    64'h99);
      push("sc_stray", 64'h0);
      #1;
      obs(ia.RBUSY); obs(ia.RDATA[31:0]); obs(ia.STRAY);

      // Asynchronous reset between edges.
      nb();
      ia.ISSUE = 1; ia.IADDR = 5'd3; ia.RADDR = {5'd3, 5'd7};
      nb();
      ia.ISSUE = 0;
      push("pre_rd0",   64'h1234_5678);
      push("pre_busy1", 64'h1);
      #1;
      obs(ia.RDATA[31:0]); obs(ia.RBUSY[1]);
      #1;
      RST_N = 1'b0;
      push("ar_rd0",   64'h0);
      push("ar_rd1",   64'h0);
      push("ar_busy",  64'h0);
      push("b_ar_rd1", 64'h0);
      push("b_ar_busy",64'h0);
      #1;
      obs(ia.RDATA[31:0]); obs(ia.RDATA[63:32]); obs(ia.RBUSY);
      obs(ib.RDATA[63:32]); obs(ib.RBUSY);

      // Release and confirm normal operation resumes on the reset image.
      nb();
      RST_N = 1'b1;
      ia.RADDR = {5'd29, 5'd7};
      push("post_rd0", 64'h0);
      push("post_sp",  64'h3FFC);
      #1;
      obs(ia.RDATA[31:0]); obs(ia.RDATA[63:32]);

      if (exp_q.size() != 0) chk("sb_leftover", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
